sign_response_packer: RTL and testbench

// - Signer-side producer of the per-round response consumed by the round-1 verifier: given challenge list Lc
//   (from HCP) and all T rounds of signer data, selects opened/unopened rounds and packs signature fields.
// - Challenged rounds (j in Lc): Z bundle + Cv go to consecutive slots. Unchallenged rounds: seed_star goes to

---
 rtl/sign_response_packer.sv | 169 ++++++++++++++++
 tb/tb_sign_response_packer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sign_response_packer.sv
// Signer-side response packer: selects challenged/unchallenged rounds from Lc and packs Z/Cv/seed_star slots.
// Optional macro LC_CHECK_EN enables range/duplicate validation of the challenge list.
module sign_response_packer #(
  parameter int unsigned T    = 8,
  parameter int unsigned TAU  = 4,
  parameter int unsigned IDXW = 5,
  parameter int unsigned ZW   = 4352,
  parameter int unsigned SSW  = 128,
  parameter int unsigned CVW  = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pack_start,
  input  logic [TAU*IDXW-1:0]     lc_i,
  input  logic [T*ZW-1:0]         z_all_i,
  input  logic [T*SSW-1:0]        seed_star_all_i,
  input  logic [T*CVW-1:0]        cv_all_i,
  output logic [TAU*ZW-1:0]       z_o,
  output logic [TAU*CVW-1:0]      cv_o,
  output logic [(T-TAU)*SSW-1:0]  seed_star_o,
  output logic                    pack_err,
  output logic                    pack_end
);

  localparam int unsigned JW = $clog2(T) + 1;
  localparam int unsigned CW = $clog2(TAU + 1);
  localparam int unsigned UW = $clog2(T - TAU + 1);

  typedef enum logic [1:0] {IDLE, CHECK, SCAN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [JW-1:0]            j_q, j_d;
  logic [CW-1:0]            cnt_c_q, cnt_c_d;
  logic [UW-1:0]            cnt_u_q, cnt_u_d;
  logic [TAU*IDXW-1:0]      lc_q, lc_d;
  logic [TAU*ZW-1:0]        z_q, z_d;
  logic [TAU*CVW-1:0]       cv_q, cv_d;
  logic [(T-TAU)*SSW-1:0]   ss_q, ss_d;
  logic                     err_q, err_d;
  logic                     end_q, end_d;
  logic                     hit;
  logic                     bad;

  assign z_o         = z_q;
  assign cv_o        = cv_q;
  assign seed_star_o = ss_q;
  assign pack_err    = err_q;
  assign pack_end    = end_q;

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    cnt_c_d = cnt_c_q;
    cnt_u_d = cnt_u_q;
    lc_d    = lc_q;
    z_d     = z_q;
    cv_d    = cv_q;
    ss_d    = ss_q;
    err_d   = err_q;
    end_d   = end_q;
    hit     = 1'b0;
    bad     = 1'b0;

    // Membership is by equality only, so duplicate entries still count once.
    for (int unsigned i = 0; i < TAU; i++) begin
      if (lc_q[(TAU-1-i)*IDXW +: IDXW] == IDXW'(j_q)) hit = 1'b1;
    end

`ifdef LC_CHECK_EN
    for (int unsigned i = 0; i < TAU; i++) begin
      if (lc_q[(TAU-1-i)*IDXW +: IDXW] >= IDXW'(T)) bad = 1'b1;
      for (int unsigned k = i + 1; k < TAU; k++) begin
        if (lc_q[(TAU-1-i)*IDXW +: IDXW] == lc_q[(TAU-1-k)*IDXW +: IDXW]) bad = 1'b1;
      end
    end
`else
    bad = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (end_q && !pack_start) begin
          end_d = 1'b0;
          err_d = 1'b0;
        end else if (pack_start && !end_q) begin
          lc_d    = lc_i;
          z_d     = '0;
          cv_d    = '0;
          ss_d    = '0;
          err_d   = 1'b0;
          j_d     = '0;
          cnt_c_d = '0;
          cnt_u_d = '0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!pack_start) begin
          z_d     = '0;
          cv_d    = '0;
          ss_d    = '0;
          state_d = IDLE;
        end else if (bad) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          j_d     = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (!pack_start) begin
          z_d     = '0;
          cv_d    = '0;
          ss_d    = '0;
          j_d     = '0;
          cnt_c_d = '0;
          cnt_u_d = '0;
          state_d = IDLE;
        end else begin
          if (hit) begin
            if (cnt_c_q < CW'(TAU)) begin
              z_d[(TAU-1-32'(cnt_c_q))*ZW +: ZW]   = z_all_i[(T-1-32'(j_q))*ZW +: ZW];
              cv_d[(TAU-1-32'(cnt_c_q))*CVW +: CVW] = cv_all_i[(T-1-32'(j_q))*CVW +: CVW];
              cnt_c_d = cnt_c_q + 1'b1;
            end
          end else if (cnt_u_q < UW'(T - TAU)) begin
            ss_d[(T-TAU-1-32'(cnt_u_q))*SSW +: SSW] = seed_star_all_i[(T-1-32'(j_q))*SSW +: SSW];
            cnt_u_d = cnt_u_q + 1'b1;
          end
          if (j_q == JW'(T - 1)) state_d = DONE;
          else                   j_d     = j_q + 1'b1;
        end
      end
      DONE: begin
        end_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      j_q     <= '0;
      cnt_c_q <= '0;
      cnt_u_q <= '0;
      lc_q    <= '0;
      z_q     <= '0;
      cv_q    <= '0;
      ss_q    <= '0;
      err_q   <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      cnt_c_q <= cnt_c_d;
      cnt_u_q <= cnt_u_d;
      lc_q    <= lc_d;
      z_q     <= z_d;
      cv_q    <= cv_d;
      ss_q    <= ss_d;
      err_q   <= err_d;
      end_q   <= end_d;
    end
  end

endmodule

// File: tb/tb_sign_response_packer.sv
// Scoreboard bench for sign_response_packer; expectations follow LC_CHECK_EN when it is defined.
module tb_sign_response_packer;

  localparam int T    = 8;
  localparam int TAU  = 4;
  localparam int IDXW = 5;
  localparam int ZW   = 4352;
  localparam int SSW  = 128;
  localparam int CVW  = 256;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   pack_start;
  logic [TAU*IDXW-1:0]    lc_i;
  logic [T*ZW-1:0]        z_all_i;
  logic [T*SSW-1:0]       seed_star_all_i;
  logic [T*CVW-1:0]       cv_all_i;
  logic [TAU*ZW-1:0]      z_o;
  logic [TAU*CVW-1:0]     cv_o;
  logic [(T-TAU)*SSW-1:0] seed_star_o;
  logic                   pack_err;
  logic                   pack_end;

  typedef int lc_t[TAU];
  typedef int ur_t[T-TAU];

  typedef struct {
    logic [TAU*ZW-1:0]      z;
    logic [TAU*CVW-1:0]     cv;
    logic [(T-TAU)*SSW-1:0] ss;
    logic                   err;
    int                     lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  sign_response_packer #(
    .T(T), .TAU(TAU), .IDXW(IDXW), .ZW(ZW), .SSW(SSW), .CVW(CVW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pack_start     (pack_start),
    .lc_i           (lc_i),
    .z_all_i        (z_all_i),
    .seed_star_all_i(seed_star_all_i),
    .cv_all_i       (cv_all_i),
    .z_o            (z_o),
    .cv_o           (cv_o),
    .seed_star_o    (seed_star_o),
    .pack_err       (pack_err),
    .pack_end       (pack_end)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rb(input int r);
    return 8'(8'h10 + r);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_lc(input lc_t l);
    for (int i = 0; i < TAU; i++) lc_i[(TAU-1-i)*IDXW +: IDXW] = IDXW'(l[i]);
  endtask

  // zr/sr list the round held by each slot; -1 leaves the slot zero.
  task automatic push_exp(input lc_t zr, input ur_t sr, input logic err, input int lat);
    exp_t e;
    e.z  = '0;
    e.cv = '0;
    e.ss = '0;
    for (int s = 0; s < TAU; s++) begin
      if (zr[s] >= 0) begin
        e.z[(TAU-1-s)*ZW +: ZW]    = {(ZW/8){rb(zr[s])}};
        e.cv[(TAU-1-s)*CVW +: CVW] = {(CVW/8){rb(zr[s])}};
      end
    end
    for (int s = 0; s < T-TAU; s++) begin
      if (sr[s] >= 0) e.ss[(T-TAU-1-s)*SSW +: SSW] = {(SSW/8){rb(sr[s])}};
    end
    e.err = err;
    e.lat = lat;
    sb.push_back(e);
  endtask

  // Drives one request, waits for pack_end, pops the scoreboard and compares.
  task automatic run_pack(input string tag, input lc_t l, input int hold);
    exp_t e;
    int   lat;
    set_lc(l);
    pack_start = 1'b1;
    tick;
    lat = 0;
    while (!pack_end && lat < 40) begin
      tick;
      lat++;
    end
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard_empty got=0 entries required>=1", tag);
      pack_start = 1'b0;
      tick;
      return;
    end
    e = sb.pop_front();
    if (lat !== e.lat) begin
      n_fail++;
      $display("FAIL %s latency got=%0d required=%0d", tag, lat, e.lat);
    end
    n_tests++;
    if (pack_err !== e.err) begin
      n_fail++;
      $display("FAIL %s pack_err got=%b required=%b", tag, pack_err, e.err);
    end
    for (int s = 0; s < TAU; s++) begin
      n_tests++;
      if (z_o[(TAU-1-s)*ZW +: ZW] !== e.z[(TAU-1-s)*ZW +: ZW] ||
          cv_o[(TAU-1-s)*CVW +: CVW] !== e.cv[(TAU-1-s)*CVW +: CVW]) begin
        n_fail++;
        $display("FAIL %s z_cv_slot%0d got=%h/%h required=%h/%h", tag, s,
                 z_o[(TAU-1-s)*ZW + ZW-32 +: 32], cv_o[(TAU-1-s)*CVW + CVW-32 +: 32],
                 e.z[(TAU-1-s)*ZW + ZW-32 +: 32], e.cv[(TAU-1-s)*CVW + CVW-32 +: 32]);
      end
    end
    for (int s = 0; s < T-TAU; s++) begin
      n_tests++;
      if (seed_star_o[(T-TAU-1-s)*SSW +: SSW] !== e.ss[(T-TAU-1-s)*SSW +: SSW]) begin
        n_fail++;
        $display("FAIL %s seed_star_slot%0d got=%h required=%h", tag, s,
                 seed_star_o[(T-TAU-1-s)*SSW + SSW-32 +: 32], e.ss[(T-TAU-1-s)*SSW + SSW-32 +: 32]);
      end
    end
    for (int h = 0; h < hold; h++) begin
      tick;
      n_tests++;
      if (pack_end !== 1'b1 || z_o !== e.z || seed_star_o !== e.ss) begin
        n_fail++;
        $display("FAIL %s hold_cycle%0d pack_end got=%b required=1 (outputs_same=%b)",
                 tag, h, pack_end, (z_o === e.z && seed_star_o === e.ss));
      end
    end
    pack_start = 1'b0;
    tick;
    n_tests++;
    if (pack_end !== 1'b0 || pack_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s release end/err got=%b/%b required=0/0", tag, pack_end, pack_err);
    end
    n_tests++;
    if (z_o !== e.z || cv_o !== e.cv || seed_star_o !== e.ss) begin
      n_fail++;
      $display("FAIL %s retain_after_release got_z_top=%h required_z_top=%h", tag,
               z_o[TAU*ZW-1 -: 32], e.z[TAU*ZW-1 -: 32]);
    end
  endtask

  task automatic test_reset;
    reset      = 1'b1;
    pack_start = 1'b0;
    lc_i       = '0;
    repeat (3) tick;
    n_tests++;
    if (pack_end !== 1'b0 || pack_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset end/err got=%b/%b required=0/0", pack_end, pack_err);
    end
    n_tests++;
    if (z_o !== '0 || cv_o !== '0 || seed_star_o !== '0) begin
      n_fail++;
      $display("FAIL reset outputs got_z_top=%h required=0", z_o[TAU*ZW-1 -: 32]);
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_pack_basic;
    lc_t l  = '{1, 3, 4, 6};
    lc_t zr = '{1, 3, 4, 6};
    ur_t sr = '{0, 2, 5, 7};
    push_exp(zr, sr, 1'b0, T + 2);
    run_pack("basic", l, 0);
  endtask

  task automatic test_order;
    lc_t l  = '{6, 1, 4, 3};
    lc_t zr = '{1, 3, 4, 6};
    ur_t sr = '{0, 2, 5, 7};
    push_exp(zr, sr, 1'b0, T + 2);
    run_pack("unordered_lc", l, 0);
  endtask

  task automatic test_invalid;
    lc_t l_dup = '{2, 2, 5, 7};
    lc_t l_rng = '{1, 3, 4, 9};
`ifdef LC_CHECK_EN
    lc_t zr = '{-1, -1, -1, -1};
    ur_t sr = '{-1, -1, -1, -1};
    push_exp(zr, sr, 1'b1, 2);
    run_pack("dup_err", l_dup, 0);
    push_exp(zr, sr, 1'b1, 2);
    run_pack("range_err", l_rng, 0);
`else
    lc_t zr_dup = '{2, 5, 7, -1};
    ur_t sr_dup = '{0, 1, 3, 4};
    lc_t zr_rng = '{1, 3, 4, -1};
    ur_t sr_rng = '{0, 2, 5, 6};
    push_exp(zr_dup, sr_dup, 1'b0, T + 2);
    run_pack("dup_nocheck", l_dup, 0);
    push_exp(zr_rng, sr_rng, 1'b0, T + 2);
    run_pack("range_nocheck", l_rng, 0);
`endif
  endtask

  task automatic test_hold;
    lc_t l  = '{0, 2, 5, 7};
    lc_t zr = '{0, 2, 5, 7};
    ur_t sr = '{1, 3, 4, 6};
    push_exp(zr, sr, 1'b0, T + 2);
    run_pack("hold", l, 5);
  endtask

  task automatic test_back_to_back;
    lc_t la  = '{7, 0, 3, 2};
    lc_t zra = '{0, 2, 3, 7};
    ur_t sra = '{1, 4, 5, 6};
    lc_t lb  = '{5, 4, 1, 0};
    lc_t zrb = '{0, 1, 4, 5};
    ur_t srb = '{2, 3, 6, 7};
    push_exp(zra, sra, 1'b0, T + 2);
    push_exp(zrb, srb, 1'b0, T + 2);
    run_pack("b2b_a", la, 0);
    run_pack("b2b_b", lb, 0);
  endtask

  task automatic test_abort;
    lc_t l = '{1, 3, 4, 6};
    int  ends;
    set_lc(l);
    pack_start = 1'b1;
    repeat (5) tick;
    n_tests++;
    if (z_o[TAU*ZW-1 -: ZW] !== {(ZW/8){rb(1)}}) begin
      n_fail++;
      $display("FAIL abort partial_slot0 got=%h required=%h", z_o[TAU*ZW-1 -: 32], {4{rb(1)}});
    end
    pack_start = 1'b0;
    tick;
    n_tests++;
    if (z_o !== '0 || cv_o !== '0 || seed_star_o !== '0 || pack_end !== 1'b0) begin
      n_fail++;
      $display("FAIL abort cleared got_z_top=%h end=%b required=0/0", z_o[TAU*ZW-1 -: 32], pack_end);
    end
    ends = 0;
    repeat (12) begin
      tick;
      if (pack_end === 1'b1) ends++;
    end
    n_tests++;
    if (ends !== 0) begin
      n_fail++;
      $display("FAIL abort no_end got=%0d cycles_high required=0", ends);
    end
  endtask

  task automatic test_reset_mid;
    lc_t l = '{1, 3, 4, 6};
    set_lc(l);
    pack_start = 1'b1;
    repeat (7) tick;
    n_tests++;
    if (seed_star_o === '0) begin
      n_fail++;
      $display("FAIL reset_mid partial got=%h required=nonzero", seed_star_o[(T-TAU)*SSW-1 -: 32]);
    end
    reset = 1'b1;
    tick;
    n_tests++;
    if (z_o !== '0 || cv_o !== '0 || seed_star_o !== '0 || pack_end !== 1'b0 || pack_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid cleared got_z_top=%h end=%b err=%b required=0", z_o[TAU*ZW-1 -: 32],
               pack_end, pack_err);
    end
    reset      = 1'b0;
    pack_start = 1'b0;
    repeat (2) tick;
    test_pack_basic();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running required=finished");
    $fatal(1);
  end

  initial begin
    for (int j = 0; j < T; j++) begin
      z_all_i[(T-1-j)*ZW +: ZW]           = {(ZW/8){rb(j)}};
      seed_star_all_i[(T-1-j)*SSW +: SSW] = {(SSW/8){rb(j)}};
      cv_all_i[(T-1-j)*CVW +: CVW]        = {(CVW/8){rb(j)}};
    end
    test_reset();
    test_pack_basic();
    test_order();
    test_invalid();
    test_hold();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
